// File: rtl/sm_rgb_led_bank.sv
// Colour-indicator bank: each accepted colour code lights the next RGB LED,
// with a re-trigger hold-off and either auto-clear-when-full or circular overwrite.
module sm_rgb_led_bank #(
    parameter int NUM_LEDS         = 3,
    parameter int HOLDOFF_CYCLES   = 12000,
    parameter int FULL_HOLD_CYCLES = 800000,
    parameter int WRAP             = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        color,
    input  logic                              clear,
    output logic [3*NUM_LEDS-1:0]             led_bus,
    output logic [1:0]                        indicator,
    output logic [$clog2(NUM_LEDS+1)-1:0]     count,
    output logic                              full,
    output logic                              busy
);

    localparam int CNT_W  = $clog2(NUM_LEDS + 1);
    localparam int PTR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int T_MAX  = (HOLDOFF_CYCLES > FULL_HOLD_CYCLES) ? HOLDOFF_CYCLES : FULL_HOLD_CYCLES;
    localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] FULL_LAST = TMR_W'(FULL_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NUM_LEDS);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLDOFF   = 2'd1,
        FULL_HOLD = 2'd2
    } state_t;

    state_t             state_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [1:0]         indicator_reg;

    logic               full_now;
    logic               capture_en;
    logic               blank_en;
    logic [2:0]         rgb_next;

    assign full_now = (count_reg == CNT_FULL);

    // A full bank only accepts new colours when overwriting the oldest slot.
    assign capture_en = (state_reg == IDLE) && (color != 2'b00) &&
                        ((WRAP != 0) || !full_now);

    assign blank_en = (state_reg == FULL_HOLD) && (timer_reg == FULL_LAST);

    always_comb begin
        rgb_next = 3'b000;
        case (color)
            2'b01:   rgb_next = 3'b001;
            2'b10:   rgb_next = 3'b100;
            2'b11:   rgb_next = 3'b010;
            default: rgb_next = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            indicator_reg <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (capture_en) begin
                        indicator_reg <= color;
                        if (!full_now) begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                        if (wr_ptr_reg == PTR_LAST) begin
                            wr_ptr_reg <= '0;
                        end else begin
                            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                        end
                        timer_reg <= '0;
                        state_reg <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (timer_reg == HOLD_LAST) begin
                        timer_reg <= '0;
                        state_reg <= ((WRAP == 0) && full_now) ? FULL_HOLD : IDLE;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                FULL_HOLD: begin
                    if (blank_en) begin
                        timer_reg     <= '0;
                        count_reg     <= '0;
                        wr_ptr_reg    <= '0;
                        indicator_reg <= 2'b00;
                        state_reg     <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    timer_reg <= '0;
                end
            endcase
        end
    end

    // One register per LED slot; only the slot under the write pointer loads.
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_slot
            logic [2:0] slot_reg;

            always_ff @(posedge clk) begin
                if (rst || clear || blank_en) begin
                    slot_reg <= 3'b000;
                end else if (capture_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= rgb_next;
                end
            end

            assign led_bus[3*gi +: 3] = slot_reg;
        end
    endgenerate

    assign indicator = indicator_reg;
    assign count     = count_reg;
    assign full      = full_now;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sm_rgb_led_bank.sv
// Bench for sm_rgb_led_bank: three configurations share one directed stimulus and
// are checked every cycle against a timing model plus hand-computed literals.
module tb_sm_rgb_led_bank;

    localparam int NI = 3;
    localparam int P_N[NI] = '{3, 3, 1};
    localparam int P_H[NI] = '{12, 4, 3};
    localparam int P_F[NI] = '{80, 10, 5};
    localparam int P_W[NI] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] color = 2'b00;

    logic [8:0] led0, led1;
    logic [2:0] led2;
    logic [1:0] ind0, ind1, ind2;
    logic [1:0] cnt0, cnt1;
    logic       cnt2;
    logic       full0, full1, full2, busy0, busy1, busy2;

    always #5 clk = ~clk;

    sm_rgb_led_bank #(.NUM_LEDS(3), .HOLDOFF_CYCLES(12), .FULL_HOLD_CYCLES(80), .WRAP(0)) u0 (
        .clk(clk), .rst(rst), .color(color), .clear(clear), .led_bus(led0),
        .indicator(ind0), .count(cnt0), .full(full0), .busy(busy0));
    sm_rgb_led_bank #(.NUM_LEDS(3), .HOLDOFF_CYCLES(4), .FULL_HOLD_CYCLES(10), .WRAP(1)) u1 (
        .clk(clk), .rst(rst), .color(color), .clear(clear), .led_bus(led1),
        .indicator(ind1), .count(cnt1), .full(full1), .busy(busy1));
    sm_rgb_led_bank #(.NUM_LEDS(1), .HOLDOFF_CYCLES(3), .FULL_HOLD_CYCLES(5), .WRAP(0)) u2 (
        .clk(clk), .rst(rst), .color(color), .clear(clear), .led_bus(led2),
        .indicator(ind2), .count(cnt2), .full(full2), .busy(busy2));

    logic [8:0] a_led[NI];
    logic [1:0] a_ind[NI];
    logic [1:0] a_cnt[NI];
    logic       a_full[NI];
    logic       a_busy[NI];
    assign a_led[0] = led0;           assign a_led[1] = led1;  assign a_led[2] = {6'b0, led2};
    assign a_ind[0] = ind0;           assign a_ind[1] = ind1;  assign a_ind[2] = ind2;
    assign a_cnt[0] = cnt0;           assign a_cnt[1] = cnt1;  assign a_cnt[2] = {1'b0, cnt2};
    assign a_full[0] = full0;         assign a_full[1] = full1; assign a_full[2] = full2;
    assign a_busy[0] = busy0;         assign a_busy[1] = busy1; assign a_busy[2] = busy2;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUTs on the last rising edge.
    logic       s_rst, s_clr, started = 1'b0;
    logic [1:0] s_col;
    always @(posedge clk) begin
        s_rst <= rst;
        s_clr <= clear;
        s_col <= color;
        if (rst) started <= 1'b1;
    end

    // Model: lit slots, count, write slot, and remaining hold-off / full-hold cycles.
    int m_led[NI][3];
    int m_cnt[NI], m_ptr[NI], m_ind[NI], m_hold[NI], m_full[NI];

    function automatic int cmap(input int c);
        case (c)
            1: return 1;
            2: return 4;
            3: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_blank(input int i);
        for (int k = 0; k < 3; k++) m_led[i][k] = 0;
        m_cnt[i] = 0;
        m_ptr[i] = 0;
        m_ind[i] = 0;
    endtask

    task automatic model_step(input int i);
        if (s_rst || s_clr) begin
            model_blank(i);
            m_hold[i] = 0;
            m_full[i] = 0;
        end else if (m_hold[i] > 0) begin
            m_hold[i]--;
            if (m_hold[i] == 0 && P_W[i] == 0 && m_cnt[i] == P_N[i]) m_full[i] = P_F[i];
        end else if (m_full[i] > 0) begin
            m_full[i]--;
            if (m_full[i] == 0) model_blank(i);
        end else if (s_col != 2'b00 && (P_W[i] == 1 || m_cnt[i] < P_N[i])) begin
            m_led[i][m_ptr[i]] = cmap(int'(s_col));
            m_ind[i] = int'(s_col);
            if (m_cnt[i] < P_N[i]) m_cnt[i]++;
            m_ptr[i] = (m_ptr[i] + 1) % P_N[i];
            m_hold[i] = P_H[i];
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                logic [8:0] exp_led;
                model_step(i);
                exp_led = '0;
                for (int k = 0; k < P_N[i]; k++) exp_led[3*k +: 3] = 3'(m_led[i][k]);
                check($sformatf("u%0d.led_bus", i), 32'(a_led[i]), 32'(exp_led));
                check($sformatf("u%0d.indicator", i), 32'(a_ind[i]), 32'(m_ind[i]));
                check($sformatf("u%0d.count", i), 32'(a_cnt[i]), 32'(m_cnt[i]));
                check($sformatf("u%0d.full", i), 32'(a_full[i]), 32'(m_cnt[i] == P_N[i]));
                check($sformatf("u%0d.busy", i), 32'(a_busy[i]), 32'(m_hold[i] > 0 || m_full[i] > 0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("reset.led_bus", 32'(led0), 0);
        check("reset.count", 32'(cnt0), 0);
        check("reset.busy", 32'(busy0), 0);
        check("reset.indicator", 32'(ind0), 0);
        $display("txn reset: led_bus=%b count=%0d busy=%0d", led0, cnt0, busy0);
        rst = 1'b0;

        // Single red capture, then hold-off length
        color = 2'b01;
        tick(1);
        color = 2'b00;
        check("red.led_bus", 32'(led0), 32'h001);
        check("red.indicator", 32'(ind0), 1);
        check("red.count", 32'(cnt0), 1);
        check("red.busy", 32'(busy0), 1);
        check("red.n1_full", 32'(full2), 1);
        check("red.n1_led", 32'(led2), 32'h1);
        $display("txn red: led_bus=%b indicator=%0d count=%0d", led0, ind0, cnt0);
        tick(11);
        check("holdoff.busy_last", 32'(busy0), 1);
        tick(1);
        check("holdoff.busy_end", 32'(busy0), 0);
        $display("txn holdoff: busy=%0d", busy0);

        // Blue held steady fills the bank, then auto-clear
        pulse_clear();
        color = 2'b10;
        tick(27);
        color = 2'b00;
        check("blue.led_bus", 32'(led0), 32'h124);
        check("blue.full", 32'(full0), 1);
        $display("txn blue fill: led_bus=%b full=%0d", led0, full0);
        tick(91);
        check("autoclr.count_before", 32'(cnt0), 3);
        tick(1);
        check("autoclr.led_bus", 32'(led0), 0);
        check("autoclr.count", 32'(cnt0), 0);
        check("autoclr.indicator", 32'(ind0), 0);
        $display("txn auto-clear: led_bus=%b count=%0d", led0, cnt0);

        // Circular overwrite: red, blue, green, red
        pulse_clear();
        foreach (P_N[j]) begin end
        for (int s = 0; s < 4; s++) begin
            logic [1:0] seq[4];
            seq = '{2'b01, 2'b10, 2'b11, 2'b01};
            color = seq[s];
            tick(1);
            color = 2'b00;
            tick(12);
            $display("txn wrap capture %0d: color=%0d led_bus=%b", s, seq[s], led1);
        end
        check("wrap.led_bus", 32'(led1), 32'h0A1);
        check("wrap.count", 32'(cnt1), 3);
        check("wrap.full", 32'(full1), 1);
        tick(30);
        check("wrap.no_autoclr", 32'(led1), 32'h0A1);

        // Green pulses inside the hold-off window are ignored
        pulse_clear();
        color = 2'b01;
        tick(1);
        color = 2'b11;
        tick(4);
        check("ignore.count", 32'(cnt1), 1);
        tick(1);
        color = 2'b00;
        check("ignore.led_bus", 32'(led1), 32'h011);
        check("ignore.count2", 32'(cnt1), 2);
        $display("txn hold-off ignore: led_bus=%b count=%0d", led1, cnt1);

        // clear wins over a simultaneous colour
        clear = 1'b1;
        color = 2'b11;
        tick(1);
        clear = 1'b0;
        check("clrwin.led_bus", 32'(led1), 0);
        check("clrwin.count", 32'(cnt1), 0);
        check("clrwin.busy", 32'(busy1), 0);
        tick(1);
        color = 2'b00;
        check("clrwin.next_led", 32'(led1), 32'h002);
        check("clrwin.next_count", 32'(cnt1), 1);
        $display("txn clear+green: led_bus=%b count=%0d", led1, cnt1);

        // rst during FULL_HOLD
        pulse_clear();
        color = 2'b10;
        tick(27);
        color = 2'b00;
        tick(20);
        check("fullhold.busy", 32'(busy0), 1);
        check("fullhold.full", 32'(full0), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstfh.led_bus", 32'(led0), 0);
        check("rstfh.count", 32'(cnt0), 0);
        check("rstfh.busy", 32'(busy0), 0);
        check("rstfh.indicator", 32'(ind0), 0);
        color = 2'b01;
        tick(1);
        color = 2'b00;
        check("rstfh.recapture", 32'(led0), 32'h001);
        $display("txn rst in full-hold: led_bus=%b count=%0d", led0, cnt0);
        tick(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_rgb_led_bank.md
Name: sm_rgb_led_bank

Overview:
- Parametrised colour-indicator bank for the soil-monitoring bot. It is the successor to the fixed 3-LED indicator.
- Accepts 2-bit colour codes from the colour-detection path and lights the next free RGB LED in a bank of NUM_LEDS.
- Enforces a re-trigger hold-off so one detection does not fill several LEDs.
- Supports two modes: auto-clear after the bank is full, or circular overwrite.
- Sits between the colour-detection block and the LED pins. Runs on the 800 kHz system clock.

Parameters:
- NUM_LEDS, 3, number of RGB LEDs in the bank (>=1).
- HOLDOFF_CYCLES, 12000, clk cycles after a capture during which new colours are ignored (>=1).
- FULL_HOLD_CYCLES, 800000, cycles the full bank stays lit before auto-clear (>=1; used only when WRAP=0).
- WRAP, 0, 0 = stop-when-full then auto-clear; 1 = circular overwrite of the oldest LED.

Ports:
- clk  input  1  system clock, 800 kHz, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- color  input  2  detected colour: 00 none, 01 red, 10 blue, 11 green.
- clear  input  1  synchronous single-cycle request to blank the bank.
- led_bus  output  3*NUM_LEDS  LED k occupies bits [3k+2:3k], ordered {b,g,r}.
- indicator  output  2  last captured colour code.
- count  output  clog2(NUM_LEDS+1)  number of lit LEDs.
- full  output  1  high when count==NUM_LEDS.
- busy  output  1  high when state!=IDLE.

Behaviour:
- Reset: all outputs registered and forced to 0; state=IDLE; wr_ptr=0; timer=0.
- Colour map: 01 -> 3'b001, 10 -> 3'b100, 11 -> 3'b010, 00 -> no capture.
- State machine has three states: IDLE, HOLDOFF, FULL_HOLD.
- IDLE, color!=00, and not full:
  - Writes the slot at wr_ptr; indicator<=color; count++; wr_ptr++ (WRAP=1 wraps from NUM_LEDS-1 to 0).
  - timer<=0; state<=HOLDOFF.
  - Latency: LED and indicator update on the edge that samples color, so they are visible 1 cycle after color is applied.
- IDLE, full, WRAP=1: capture proceeds. It overwrites slot wr_ptr (the oldest); count stays NUM_LEDS.
- HOLDOFF:
  - timer increments each cycle and color is ignored.
  - At timer==HOLDOFF_CYCLES-1: timer<=0.
  - Next state is FULL_HOLD if WRAP=0 and full, else IDLE.
  - A colour held steady re-captures on the first IDLE cycle, so exactly HOLDOFF_CYCLES+1 cycles separate captures.
- FULL_HOLD (WRAP=0 only):
  - timer counts to FULL_HOLD_CYCLES-1 and colours are ignored.
  - On expiry: led_bus<=0, count<=0, wr_ptr<=0, indicator<=00, state<=IDLE.
- clear:
  - In any state, has the same effect as rst except priority: rst > clear > capture.
  - clear and color!=00 in the same cycle: clear wins and the colour is dropped.
  - A capture is possible on the next cycle.
- full, busy: derived from registered state and count; no combinational path from color.
- NUM_LEDS=1: full after the first capture, then FULL_HOLD (WRAP=0) or overwrite of slot 0 (WRAP=1).
- Timer width is clog2(max(HOLDOFF_CYCLES, FULL_HOLD_CYCLES)); it must never overflow.
- rst mid-HOLDOFF or mid-FULL_HOLD: immediate return to reset values on the next edge.

Test Plan:
- Reset then color=01 for 1 cycle (defaults) -> next cycle led_bus[2:0]=001, indicator=01, count=1, busy=1; after 12000 cycles busy=0.
- color=10 held steady (defaults) -> LED0=100 at t+1, LED1=100 at t+12002, LED2=100 at t+24003, full=1; after 12000+800000 more cycles led_bus=0, count=0, indicator=00.
- WRAP=1, NUM_LEDS=3, HOLDOFF_CYCLES=4, sequence red, blue, green, red (each after hold-off) -> LED0=001 (overwritten), LED1=100, LED2=010; count=3; full=1; no auto-clear.
- HOLDOFF_CYCLES=4: red capture, then green pulses during cycles 1-4 after it -> ignored; green on cycle 5 -> captured into LED1.
- clear asserted with color=11 in the same cycle while count=2 -> led_bus=0, count=0, state IDLE; green captured into LED0 the next cycle if still present.
- rst asserted during FULL_HOLD -> all outputs 0 on the next edge; a new capture lands in LED0.
